// File: rtl/median_frame_buffer_pkg.sv
// Shared types and entry layout for the median frame buffer.
package median_frame_buffer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DROP  = 2'd2
  } mfb_state_e;

  // Flag bits sit directly above the sample in each FIFO entry.
  localparam int unsigned DAT_LSB = 0;
  localparam int unsigned SOF_OFS = 0;
  localparam int unsigned EOF_OFS = 1;
  localparam int unsigned FLAG_W  = 2;

endpackage

// File: rtl/sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO with registered occupancy count.
module sync_fifo_fwft #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push, pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign push    = wr_en & ~full;
  assign pop     = rd_en & ~empty;
  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/median_frame_buffer.sv
// Frames a free-running dat/val stream into SOF/EOF-tagged valid/ready beats via a FIFO.
module median_frame_buffer
  import median_frame_buffer_pkg::*;
#(
  parameter int unsigned WORD_LEN = 8,
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned LEN_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WORD_LEN-1:0] dat_i,
  input  logic                val_i,
  output logic [WORD_LEN-1:0] m_dat,
  output logic                m_sof,
  output logic                m_eof,
  output logic                m_val,
  input  logic                m_rdy,
  output logic                stat_val,
  output logic [LEN_W-1:0]    stat_len,
  output logic                stat_trunc,
  output logic                ovf,
  input  logic                ovf_clr
);

  localparam int unsigned ENTRY_W = WORD_LEN + FLAG_W;
  localparam int unsigned SOF_BIT = WORD_LEN + SOF_OFS;
  localparam int unsigned EOF_BIT = WORD_LEN + EOF_OFS;
  localparam int unsigned CW      = $clog2(DEPTH) + 1;

  mfb_state_e          state_q, state_d;
  logic [WORD_LEN-1:0] h_dat_q, h_dat_d;
  logic                h_sof_q, h_sof_d;
  logic [LEN_W-1:0]    len_q, len_d, len_inc;
  logic                ovf_q, ovf_d;
  logic                stat_val_q, stat_val_d;
  logic [LEN_W-1:0]    stat_len_q, stat_len_d;
  logic                stat_trunc_q, stat_trunc_d;

  logic                fifo_wr, fifo_eof, fifo_full, fifo_empty;
  logic [ENTRY_W-1:0]  fifo_wdata, fifo_rdata;
  logic [CW-1:0]       fifo_count;
  logic                room1, room2, close, close_trunc, ovf_set;

  // Admission sees only the registered count; a same-cycle pop is not credited.
  assign room1   = ~fifo_full;
  assign room2   = (fifo_count <= CW'(DEPTH - 2));
  assign len_inc = (len_q == {LEN_W{1'b1}}) ? len_q : len_q + LEN_W'(1);

  assign fifo_wdata = {fifo_eof, h_sof_q, h_dat_q};

  sync_fifo_fwft #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (fifo_wr),
    .wr_data (fifo_wdata),
    .rd_en   (m_rdy),
    .rd_data (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      h_dat_q      <= '0;
      h_sof_q      <= 1'b0;
      len_q        <= '0;
      ovf_q        <= 1'b0;
      stat_val_q   <= 1'b0;
      stat_len_q   <= '0;
      stat_trunc_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      h_dat_q      <= h_dat_d;
      h_sof_q      <= h_sof_d;
      len_q        <= len_d;
      ovf_q        <= ovf_d;
      stat_val_q   <= stat_val_d;
      stat_len_q   <= stat_len_d;
      stat_trunc_q <= stat_trunc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (val_i) state_d = ST_BURST;
      ST_BURST: begin
        if (val_i) begin
          if (!room2) state_d = ST_DROP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DROP:  if (!val_i) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    fifo_wr     = 1'b0;
    fifo_eof    = 1'b0;
    h_dat_d     = h_dat_q;
    h_sof_d     = h_sof_q;
    len_d       = len_q;
    close       = 1'b0;
    close_trunc = 1'b0;
    ovf_set     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (val_i) begin
          h_dat_d = dat_i;
          h_sof_d = 1'b1;
          len_d   = '0;
        end
      end
      ST_BURST: begin
        if (val_i && room2) begin
          fifo_wr = 1'b1;
          h_dat_d = dat_i;
          h_sof_d = 1'b0;
          len_d   = len_inc;
        end else if (room1) begin
          // Either the natural end or a forced one when only one slot remains.
          fifo_wr     = 1'b1;
          fifo_eof    = 1'b1;
          len_d       = len_inc;
          close       = 1'b1;
          close_trunc = val_i;
          ovf_set     = val_i;
        end else begin
          close       = 1'b1;
          close_trunc = 1'b1;
          ovf_set     = 1'b1;
        end
      end
      default: ;
    endcase
    stat_val_d   = close;
    stat_len_d   = close ? len_d : stat_len_q;
    stat_trunc_d = close ? close_trunc : stat_trunc_q;
    ovf_d        = ovf_set | (ovf_q & ~ovf_clr);
  end

  assign m_val      = ~fifo_empty;
  assign m_dat      = m_val ? fifo_rdata[WORD_LEN-1:0] : '0;
  assign m_sof      = m_val & fifo_rdata[SOF_BIT];
  assign m_eof      = m_val & fifo_rdata[EOF_BIT];
  assign stat_val   = stat_val_q;
  assign stat_len   = stat_len_q;
  assign stat_trunc = stat_trunc_q;
  assign ovf        = ovf_q;

endmodule
